// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: captures ALU outputs and EX control, resolves
// conditional branches in MEM and keeps saturating branch statistics.
module ex_mem_stage #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             ex_valid,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [XLEN-1:0]  ex_imm,
    input  logic [XLEN-1:0]  ex_alu_result,
    input  logic             ex_zero,
    input  logic             ex_sign,
    input  logic [XLEN-1:0]  ex_rs2_data,
    input  logic [4:0]       ex_rd,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic             ex_mem_write,
    input  logic             ex_mem_to_reg,
    input  logic             ex_branch,
    input  logic [2:0]       ex_funct3,
    output logic             mem_valid,
    output logic [XLEN-1:0]  mem_alu_result,
    output logic [XLEN-1:0]  mem_rs2_data,
    output logic [4:0]       mem_rd,
    output logic             mem_reg_write,
    output logic             mem_mem_read,
    output logic             mem_mem_write,
    output logic             mem_mem_to_reg,
    output logic [XLEN-1:0]  mem_branch_target,
    output logic             mem_pc_src,
    output logic             redirect_flush,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] taken_count
);

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;
    localparam logic [2:0] F3_BGE = 3'b101;

    logic            taken_q;
    logic            cond_c;
    logic            taken_c;
    logic            squash_c;
    logic            bubble_c;
    logic            load_c;
    logic            count_c;
    logic [XLEN-1:0] target_c;

    // Branch resolution and edge-priority decode
    always_comb begin
        cond_c   = 1'b0;
        case (ex_funct3)
            F3_BEQ:  cond_c = ex_zero;
            F3_BNE:  cond_c = ~ex_zero;
            F3_BLT:  cond_c = ex_sign;
            F3_BGE:  cond_c = ~ex_sign;
            default: cond_c = 1'b0;
        endcase
        taken_c  = ex_valid & ex_branch & cond_c;
        squash_c = mem_pc_src;
        bubble_c = squash_c | flush;
        load_c   = ~bubble_c & ~stall;
        count_c  = load_c & ex_valid & ex_branch;
        target_c = ex_pc + (ex_imm << 1);
    end

    // Pipeline register; datapath fields are left untouched on a bubble
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_valid         <= 1'b0;
            mem_alu_result    <= '0;
            mem_rs2_data      <= '0;
            mem_rd            <= '0;
            mem_reg_write     <= 1'b0;
            mem_mem_read      <= 1'b0;
            mem_mem_write     <= 1'b0;
            mem_mem_to_reg    <= 1'b0;
            mem_branch_target <= '0;
            taken_q           <= 1'b0;
        end else if (bubble_c) begin
            mem_valid         <= 1'b0;
            mem_reg_write     <= 1'b0;
            mem_mem_read      <= 1'b0;
            mem_mem_write     <= 1'b0;
            mem_mem_to_reg    <= 1'b0;
            taken_q           <= 1'b0;
        end else if (!stall) begin
            mem_valid         <= ex_valid;
            mem_alu_result    <= ex_alu_result;
            mem_rs2_data      <= ex_rs2_data;
            mem_rd            <= ex_rd;
            mem_reg_write     <= ex_reg_write  & ex_valid;
            mem_mem_read      <= ex_mem_read   & ex_valid;
            mem_mem_write     <= ex_mem_write  & ex_valid;
            mem_mem_to_reg    <= ex_mem_to_reg & ex_valid;
            mem_branch_target <= target_c;
            taken_q           <= taken_c;
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk) begin
        if (reset) begin
            branch_count <= '0;
            taken_count  <= '0;
        end else if (count_c) begin
            if (branch_count != '1) begin
                branch_count <= branch_count + CNT_W'(1);
            end
            if (taken_c && (taken_count != '1)) begin
                taken_count <= taken_count + CNT_W'(1);
            end
        end
    end

    assign mem_pc_src     = mem_valid & taken_q;
    assign redirect_flush = mem_pc_src;

endmodule
